// File: rtl/dma_sched_pkg.sv
// Shared constants and types for the DMA channel scheduler: register map,
// FSM states, completion codes and STATUS bit positions.
package dma_sched_pkg;

  localparam logic [31:0] ADDR_CTRL           = 32'h0000_0404;
  localparam logic [31:0] ADDR_IO_ADDR        = 32'h0000_0408;
  localparam logic [31:0] ADDR_MEM_ADDR       = 32'h0000_040C;
  localparam logic [31:0] ADDR_STATUS         = 32'h0000_0414;
  localparam logic [31:0] ADDR_TRANSFER_COUNT = 32'h0000_0418;
  localparam logic [31:0] ADDR_ERROR_STATUS   = 32'h0000_0420;
  localparam logic [31:0] ADDR_CONFIG         = 32'h0000_0424;

  localparam logic [1:0] DONE_OK  = 2'd0;
  localparam logic [1:0] DONE_ERR = 2'd1;
  localparam logic [1:0] DONE_TMO = 2'd2;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

  localparam logic [31:0] W1C_CLEAR_ALL = 32'h0000_001F;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARB,
    S_WR_IO,
    S_WR_MEM,
    S_WR_CFG,
    S_WR_CTRL,
    S_SETTLE,
    S_RD_STAT,
    S_CHK_STAT,
    S_RD_CNT,
    S_CHK_CNT,
    S_CLR_ERR,
    S_DONE
  } state_t;

endpackage

// File: rtl/dma_prio_rr_arbiter.sv
// Combinational pick: highest priority wins, ties go to the first requester
// at or after the round-robin pointer (wrapping).
module dma_prio_rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*2-1:0]       i_prio,
  input  logic [$clog2(N_REQ)-1:0] i_rr_ptr,
  output logic                     o_gnt_valid,
  output logic [$clog2(N_REQ)-1:0] o_gnt_id
);

  localparam int ID_W = $clog2(N_REQ);

  logic [1:0] w_best;
  int         w_idx;

  // Scanning from rr_ptr with a strict '>' keeps the earliest tied index.
  always_comb begin
    o_gnt_valid = 1'b0;
    o_gnt_id    = '0;
    w_best      = 2'd0;
    w_idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = (int'(i_rr_ptr) + k) % N_REQ;
      if (i_req[w_idx] && (!o_gnt_valid || (i_prio[2*w_idx +: 2] > w_best))) begin
        o_gnt_valid = 1'b1;
        o_gnt_id    = ID_W'(w_idx);
        w_best      = i_prio[2*w_idx +: 2];
      end
    end
  end

endmodule

// File: rtl/dma_channel_scheduler.sv
// Arbitrates channel requests, programs the DMA register block for the winner,
// polls STATUS to completion or timeout and returns a one-cycle ack.
module dma_channel_scheduler
  import dma_sched_pkg::*;
#(
  parameter int          N_REQ        = 4,
  parameter int          POLL_TIMEOUT = 1024,
  parameter logic [31:0] CFG_BASE     = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*32-1:0]      req_io_addr,
  input  logic [N_REQ*32-1:0]      req_mem_addr,
  input  logic [N_REQ*15-1:0]      req_wcount,
  input  logic [N_REQ-1:0]         req_dir,
  input  logic [N_REQ*2-1:0]       req_prio,
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] done_id,
  output logic [1:0]               done_status,
  output logic [31:0]              done_count,
  output logic                     busy,
  output logic                     reg_wr_en,
  output logic                     reg_rd_en,
  output logic [31:0]              reg_addr,
  output logic [31:0]              reg_wdata,
  input  logic [31:0]              reg_rdata
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int TMO_W = $clog2(POLL_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(POLL_TIMEOUT);

  state_t            r_state;
  state_t            w_next;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   w_gnt_id;
  logic              w_gnt_valid;
  logic [31:0]       r_io;
  logic [31:0]       r_mem;
  logic [14:0]       r_wcount;
  logic              r_dir;
  logic [1:0]        r_prio;
  logic [1:0]        r_status;
  logic [31:0]       r_count;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_settle;
  logic              w_stat_err;
  logic              w_stat_done;
  logic              w_tmo_hit;

  dma_prio_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req       (req),
    .i_prio      (req_prio),
    .i_rr_ptr    (r_rr_ptr),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  assign w_stat_err  = reg_rdata[STAT_ERR_BIT];
  assign w_stat_done = reg_rdata[STAT_DONE_BIT] & ~reg_rdata[STAT_BUSY_BIT];
  assign w_tmo_hit   = (r_tmo >= TMO_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id     <= '0;
      r_rr_ptr <= '0;
      r_tmo    <= '0;
      r_settle <= 1'b0;
      r_status <= DONE_OK;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_ARB: begin
          if (w_gnt_valid) begin
            r_id     <= w_gnt_id;
            r_rr_ptr <= (w_gnt_id == ID_W'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
          end
        end
        S_WR_CTRL: begin
          r_tmo    <= '0;
          r_settle <= 1'b0;
        end
        S_SETTLE, S_RD_STAT: begin
          if (r_tmo != TMO_LIMIT) r_tmo <= r_tmo + 1'b1;
          if (r_state == S_SETTLE) r_settle <= 1'b1;
        end
        S_CHK_STAT: begin
          if (r_tmo != TMO_LIMIT) r_tmo <= r_tmo + 1'b1;
          if (w_stat_err)       r_status <= DONE_ERR;
          else if (w_stat_done) r_status <= DONE_OK;
          else if (w_tmo_hit)   r_status <= DONE_TMO;
        end
        S_CHK_CNT: r_count <= reg_rdata;
        S_CLR_ERR: r_count <= '0;
        default: ;
      endcase
    end
  end

  // Descriptor snapshot at grant; later request changes do not leak in.
  always_ff @(posedge clk) begin
    if (r_state == S_ARB) begin
      r_io     <= req_io_addr[32*int'(w_gnt_id) +: 32];
      r_mem    <= req_mem_addr[32*int'(w_gnt_id) +: 32];
      r_wcount <= req_wcount[15*int'(w_gnt_id) +: 15];
      r_dir    <= req_dir[w_gnt_id];
      r_prio   <= req_prio[2*int'(w_gnt_id) +: 2];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (|req) w_next = S_ARB;
      S_ARB:      w_next = w_gnt_valid ? S_WR_IO : S_IDLE;
      S_WR_IO:    w_next = S_WR_MEM;
      S_WR_MEM:   w_next = S_WR_CFG;
      S_WR_CFG:   w_next = S_WR_CTRL;
      S_WR_CTRL:  w_next = S_SETTLE;
      S_SETTLE:   if (r_settle) w_next = S_RD_STAT;
      S_RD_STAT:  w_next = S_CHK_STAT;
      S_CHK_STAT: begin
        if (w_stat_err)       w_next = S_CLR_ERR;
        else if (w_stat_done) w_next = S_RD_CNT;
        else if (w_tmo_hit)   w_next = S_CLR_ERR;
        else                  w_next = S_RD_STAT;
      end
      S_RD_CNT:   w_next = S_CHK_CNT;
      S_CHK_CNT:  w_next = S_DONE;
      S_CLR_ERR:  w_next = S_DONE;
      // A waiting request goes straight to arbitration for back-to-back service.
      S_DONE:     w_next = (|req) ? S_ARB : S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ack         = '0;
    done_id     = '0;
    done_status = DONE_OK;
    done_count  = '0;
    busy        = (r_state != S_IDLE);
    reg_wr_en   = 1'b0;
    reg_rd_en   = 1'b0;
    reg_addr    = '0;
    reg_wdata   = '0;
    case (r_state)
      S_WR_IO: begin
        reg_wr_en = 1'b1;
        reg_addr  = ADDR_IO_ADDR;
        reg_wdata = r_io;
      end
      S_WR_MEM: begin
        reg_wr_en = 1'b1;
        reg_addr  = ADDR_MEM_ADDR;
        reg_wdata = r_mem;
      end
      S_WR_CFG: begin
        reg_wr_en = 1'b1;
        reg_addr  = ADDR_CONFIG;
        reg_wdata = CFG_BASE | {30'h0, r_prio};
      end
      S_WR_CTRL: begin
        reg_wr_en = 1'b1;
        reg_addr  = ADDR_CTRL;
        reg_wdata = {15'h0, r_dir, r_wcount, 1'b1};
      end
      S_RD_STAT: begin
        reg_rd_en = 1'b1;
        reg_addr  = ADDR_STATUS;
      end
      S_RD_CNT: begin
        reg_rd_en = 1'b1;
        reg_addr  = ADDR_TRANSFER_COUNT;
      end
      S_CLR_ERR: begin
        reg_wr_en = 1'b1;
        reg_addr  = ADDR_ERROR_STATUS;
        reg_wdata = W1C_CLEAR_ALL;
      end
      S_DONE: begin
        ack         = N_REQ'(1) << r_id;
        done_id     = r_id;
        done_status = r_status;
        done_count  = r_count;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Directed bench for dma_channel_scheduler with a small DMA register slave model.
module tb_dma_channel_scheduler;

  localparam int N  = 4;
  localparam int PT = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*32-1:0]  req_io_addr;
  logic [N*32-1:0]  req_mem_addr;
  logic [N*15-1:0]  req_wcount;
  logic [N-1:0]     req_dir;
  logic [N*2-1:0]   req_prio;
  logic [N-1:0]     ack;
  logic [1:0]       done_id;
  logic [1:0]       done_status;
  logic [31:0]      done_count;
  logic             busy;
  logic             reg_wr_en;
  logic             reg_rd_en;
  logic [31:0]      reg_addr;
  logic [31:0]      reg_wdata;
  logic [31:0]      reg_rdata = 32'h0;

  always #5 clk = ~clk;

  dma_channel_scheduler #(.N_REQ(N), .POLL_TIMEOUT(PT), .CFG_BASE(32'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_io_addr  (req_io_addr),
    .req_mem_addr (req_mem_addr),
    .req_wcount   (req_wcount),
    .req_dir      (req_dir),
    .req_prio     (req_prio),
    .ack          (ack),
    .done_id      (done_id),
    .done_status  (done_status),
    .done_count   (done_count),
    .busy         (busy),
    .reg_wr_en    (reg_wr_en),
    .reg_rd_en    (reg_rd_en),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_rdata    (reg_rdata)
  );

  // Slave model. mode: 0 done at once, 1 error, 2 never done, 3 busy for two polls.
  int          mode = 0;
  int          polls = 0;
  logic [31:0] cnt_val = 32'h0;

  function automatic logic [31:0] stat_resp(input int m, input int p);
    case (m)
      1:       return 32'h0000_0006;
      2:       return 32'h0000_0001;
      3:       return (p < 2) ? 32'h0000_0001 : 32'h0000_0002;
      default: return 32'h0000_0002;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reg_wr_en && reg_addr == 32'h404) begin
      polls   <= 0;
      cnt_val <= {17'h0, reg_wdata[15:1]} + 32'd1;
    end
    if (reg_rd_en) begin
      if (reg_addr == 32'h414) begin
        reg_rdata <= stat_resp(mode, polls);
        polls     <= polls + 1;
      end else if (reg_addr == 32'h418) begin
        reg_rdata <= cnt_val;
      end else begin
        reg_rdata <= 32'hBAD0_BAD0;
      end
    end
  end

  typedef struct {
    int          ch;
    logic [31:0] io;
    logic [31:0] mem;
    logic [14:0] wc;
    logic        dir;
    logic [1:0]  prio;
    int          md;
    logic [31:0] e_cfg;
    logic [31:0] e_ctrl;
    logic [1:0]  e_st;
    logic [31:0] e_cnt;
    int          e_polls;
    int          e_lat;
  } vec_t;

  vec_t        vt[6];
  int          n_vec = 0;
  int          n_bad = 0;
  int          viol = 0;
  int          cyc = 0;
  string       cur_tag = "init";
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          n_stat_rd;
  int          n_cnt_rd;
  logic        ack_seen;
  int          ack_id;
  logic [1:0]  ack_st;
  logic [31:0] ack_cnt;

  function automatic vec_t mk(input int ch, input logic [31:0] io, input logic [31:0] mem,
                              input logic [14:0] wc, input logic dir, input logic [1:0] prio,
                              input int md, input logic [31:0] e_cfg, input logic [31:0] e_ctrl,
                              input logic [1:0] e_st, input logic [31:0] e_cnt,
                              input int e_polls, input int e_lat);
    vec_t v;
    v.ch = ch; v.io = io; v.mem = mem; v.wc = wc; v.dir = dir; v.prio = prio; v.md = md;
    v.e_cfg = e_cfg; v.e_ctrl = e_ctrl; v.e_st = e_st; v.e_cnt = e_cnt;
    v.e_polls = e_polls; v.e_lat = e_lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%s]: got 0x%0h, expected 0x%0h", nm, cur_tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    ack_seen = 1'b0;
    if (reg_wr_en && reg_rd_en) viol++;
    if (!reg_wr_en && !reg_rd_en && (reg_addr != 32'h0 || reg_wdata != 32'h0)) viol++;
    if (reg_wr_en) begin
      wa_q.push_back(reg_addr);
      wd_q.push_back(reg_wdata);
    end
    if (reg_rd_en && reg_addr == 32'h414) n_stat_rd++;
    if (reg_rd_en && reg_addr == 32'h418) n_cnt_rd++;
    if (ack != '0) begin
      ack_seen = 1'b1;
      ack_id   = int'(done_id);
      ack_st   = done_status;
      ack_cnt  = done_count;
      if (!$onehot(ack) || !ack[done_id] || !busy) viol++;
    end
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    n_stat_rd = 0;
    n_cnt_rd  = 0;
  endtask

  task automatic wait_busy(input int limit, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (busy) ok = 1'b1;
    end
  endtask

  task automatic wait_ack(input int limit, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      tick();
      if (ack_seen) ok = 1'b1;
    end
  endtask

  task automatic check_idle_outputs();
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", reg_wr_en, 0);
    chk("rst_rd_en", reg_rd_en, 0);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_done_status", done_status, 0);
    chk("rst_done_count", done_count, 0);
  endtask

  task automatic run_vec(input vec_t v);
    logic ok;
    int   g;
    int   nw;
    tick();
    clear_log();
    mode = v.md;
    req_io_addr[32*v.ch +: 32]  = v.io;
    req_mem_addr[32*v.ch +: 32] = v.mem;
    req_wcount[15*v.ch +: 15]   = v.wc;
    req_dir[v.ch]               = v.dir;
    req_prio[2*v.ch +: 2]       = v.prio;
    req = '0;
    req[v.ch] = 1'b1;
    wait_busy(5, ok);
    chk("grant", ok, 1);
    g = cyc;
    wait_ack(60, ok);
    chk("ack_seen", ok, 1);
    req = '0;
    chk("ack_id", ack_id, v.ch);
    chk("done_status", ack_st, v.e_st);
    chk("done_count", ack_cnt, v.e_cnt);
    chk("latency", cyc - g + 1, v.e_lat);
    nw = (v.e_st == 2'd0) ? 4 : 5;
    chk("n_writes", wa_q.size(), nw);
    if (wa_q.size() >= 4) begin
      chk("wr0", {wa_q[0], wd_q[0]}, {32'h408, v.io});
      chk("wr1", {wa_q[1], wd_q[1]}, {32'h40C, v.mem});
      chk("wr2", {wa_q[2], wd_q[2]}, {32'h424, v.e_cfg});
      chk("wr3", {wa_q[3], wd_q[3]}, {32'h404, v.e_ctrl});
    end
    if (nw == 5 && wa_q.size() >= 5) chk("wr4_clr", {wa_q[4], wd_q[4]}, {32'h420, 32'h1F});
    chk("status_polls", n_stat_rd, v.e_polls);
    chk("count_reads", n_cnt_rd, (v.e_st == 2'd0) ? 1 : 0);
    tick();
    chk("ack_pulse", ack, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    logic found;
    int   t0;
    int   exp_rr[5];

    rst_n = 1'b0;
    req = '0; req_io_addr = '0; req_mem_addr = '0; req_wcount = '0; req_dir = '0; req_prio = '0;

    vt[0] = mk(1, 32'h0000_1000, 32'h0000_2000, 15'd5,     1'b1, 2'd2, 0, 32'h2, 32'h0001_000B, 2'd0, 32'd6,      1, 12);
    vt[1] = mk(0, 32'hDEAD_0000, 32'h0000_BEEF, 15'd0,     1'b0, 2'd0, 0, 32'h0, 32'h0000_0001, 2'd0, 32'd1,      1, 12);
    vt[2] = mk(3, 32'hFFFF_FFFC, 32'h8000_0000, 15'h7FFF,  1'b1, 2'd3, 0, 32'h3, 32'h0001_FFFF, 2'd0, 32'h8000,   1, 12);
    vt[3] = mk(2, 32'h0000_0040, 32'h0000_0080, 15'd3,     1'b0, 2'd1, 1, 32'h1, 32'h0000_0007, 2'd1, 32'd0,      1, 11);
    vt[4] = mk(1, 32'h0000_1234, 32'h0000_5678, 15'd2,     1'b1, 2'd2, 2, 32'h2, 32'h0001_0005, 2'd2, 32'd0,      8, 25);
    vt[5] = mk(2, 32'h0000_00A0, 32'h0000_00B0, 15'd1,     1'b0, 2'd0, 3, 32'h0, 32'h0000_0003, 2'd0, 32'd2,      3, 16);

    cur_tag = "reset";
    tick();
    tick();
    check_idle_outputs();
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_vec(vt[i]);
    end

    cur_tag = "priority";
    tick();
    clear_log();
    mode = 0;
    req_prio[1:0] = 2'd1;
    req_prio[7:6] = 2'd3;
    req = 4'b1001;
    wait_ack(40, ok);
    chk("prio_ack1", ok, 1);
    chk("prio_id1", ack_id, 3);
    t0 = cyc;
    req[3] = 1'b0;
    wait_ack(40, ok);
    chk("prio_ack2", ok, 1);
    chk("prio_id2", ack_id, 0);
    chk("prio_gap", cyc - t0, 12);
    req = '0;
    tick();

    cur_tag = "round_robin";
    rst_n = 1'b0;
    tick();
    check_idle_outputs();
    rst_n = 1'b1;
    for (int c = 0; c < N; c++) req_prio[2*c +: 2] = 2'd2;
    exp_rr = '{0, 1, 2, 3, 0};
    req = 4'hF;
    t0 = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(40, ok);
      chk("rr_ack", ok, 1);
      chk("rr_id", ack_id, exp_rr[k]);
      if (k > 0) chk("rr_gap", cyc - t0, 12);
      t0 = cyc;
    end
    req = '0;
    tick();
    tick();

    cur_tag = "reset_mid";
    clear_log();
    mode = 2;
    req = 4'b0100;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (reg_rd_en && reg_addr == 32'h414) found = 1'b1;
    end
    chk("poll_reached", found, 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs();
    tick();
    rst_n = 1'b1;
    clear_log();
    mode = 0;
    wait_busy(5, ok);
    chk("regrant", ok, 1);
    wait_ack(40, ok);
    chk("restart_ack", ok, 1);
    chk("restart_first_addr", (wa_q.size() > 0) ? wa_q[0] : 32'h0, 32'h408);
    chk("restart_first_data", (wd_q.size() > 0) ? wd_q[0] : 32'h0, req_io_addr[95:64]);
    chk("restart_id", ack_id, 2);
    chk("restart_status", ack_st, 0);
    req = '0;
    tick();

    cur_tag = "bus";
    chk("bus_rule_violations", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
